// File: rtl/textlcd_rx.sv
// textlcd_rx
//   Receiving end of an HD44780-style character-LCD write bus. The bus is
//   sampled on clk through a SYNC_STAGES-deep pipeline; a transaction is taken
//   on the falling edge of lcd_e and decoded one cycle later. A 2x16 shadow
//   character buffer, the DDRAM address counter and the mode bits are mirrored
//   and exposed for monitoring.
//
//   Optional feature macro: TEXTLCD_RX_SHIFT_EN
//     When defined, the entry-mode S bit and the S/C=1 shift instruction
//     move disp_shift (mod 40). When undefined, those instructions are accepted
//     but change nothing, and disp_shift is tied to 0.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   lcd_e        bus enable (transaction on falling edge)
//   lcd_rs       0 = instruction, 1 = data
//   lcd_rw       0 = write, 1 = read (reads are ignored)
//   lcd_data     instruction / character code
//   rd_addr      buffer read index (0-15 line 1, 16-31 line 2)
//   rd_char      registered buffer[rd_addr], 1 cycle latency
//   cursor_addr  DDRAM address counter
//   disp_on      display-on bit
//   entry_inc    entry-mode increment bit
//   func_bits    function-set {DL,N,F}
//   busy         high during the Clear Display sweep
//   cmd_strobe   1-cycle pulse per accepted write
//   overrun      1-cycle pulse when a write arrives while busy (dropped)
//   disp_shift   display shift offset 0-39
module textlcd_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       entry_inc,
  output logic [2:0] func_bits,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       overrun,
  output logic [5:0] disp_shift
);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t      state, state_next;
  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_hist;
  logic        pend_valid, pend_rs, pend_rw;
  logic [7:0]  pend_data;
  logic [7:0]  cells [32];
  logic [4:0]  sweep_idx;
  logic        accept, clear_start;

  // Address counter step including the two-line wrap and the recovery of
  // out-of-range addresses loaded by Set DDRAM Address.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (a >= 7'h68) return 7'h00;
    if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

`ifdef TEXTLCD_RX_SHIFT_EN
  logic [5:0] shift_q;
  logic       entry_s;

  function automatic logic [5:0] step_shift(input logic [5:0] s, input logic up);
    if (up) return (s == 6'd39) ? 6'd0 : s + 6'd1;
    return (s == 6'd0) ? 6'd39 : s - 6'd1;
  endfunction

  assign disp_shift = shift_q;
`else
  assign disp_shift = '0;
`endif

  // e/rs/rw/data travel together so the decoded fields stay aligned with
  // the enable edge that qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_hist     <= 1'b0;
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_rw    <= 1'b0;
      pend_data  <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_hist     <= sync_q[SYNC_STAGES-1][10];
      pend_valid <= e_hist & ~sync_q[SYNC_STAGES-1][10];
      pend_rs    <= sync_q[SYNC_STAGES-1][9];
      pend_rw    <= sync_q[SYNC_STAGES-1][8];
      pend_data  <= sync_q[SYNC_STAGES-1][7:0];
    end
  end

  assign accept      = pend_valid & ~pend_rw;
  assign clear_start = accept & (state == ST_IDLE) & ~pend_rs & (pend_data == 8'h01);
  assign busy        = (state == ST_SWEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_SWEEP;
      ST_SWEEP: if (sweep_idx == 5'd31) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) cells[i] <= CLEAR_CHAR;
      rd_char     <= CLEAR_CHAR;
      cursor_addr <= '0;
      disp_on     <= 1'b0;
      entry_inc   <= 1'b1;
      func_bits   <= '0;
      cmd_strobe  <= 1'b0;
      overrun     <= 1'b0;
      sweep_idx   <= '0;
`ifdef TEXTLCD_RX_SHIFT_EN
      shift_q     <= '0;
      entry_s     <= 1'b0;
`endif
    end else begin
      rd_char    <= cells[rd_addr];
      cmd_strobe <= 1'b0;
      overrun    <= 1'b0;

      if (state == ST_SWEEP) begin
        cells[sweep_idx] <= CLEAR_CHAR;
        sweep_idx        <= sweep_idx + 5'd1;
      end

      if (accept) begin
        if (state == ST_SWEEP) begin
          overrun <= 1'b1;
        end else begin
          cmd_strobe <= 1'b1;
          if (pend_rs) begin
            if (cursor_addr <= 7'h0F)
              cells[{1'b0, cursor_addr[3:0]}] <= pend_data;
            else if (cursor_addr >= 7'h40 && cursor_addr <= 7'h4F)
              cells[{1'b1, cursor_addr[3:0]}] <= pend_data;
            cursor_addr <= step_addr(cursor_addr, entry_inc);
`ifdef TEXTLCD_RX_SHIFT_EN
            if (entry_s) shift_q <= step_shift(shift_q, entry_inc);
`endif
          end else begin
            casez (pend_data)
              8'b1???????: cursor_addr <= pend_data[6:0];
              8'b01??????: ;
              8'b001?????: func_bits <= pend_data[4:2];
              8'b0001????: begin
                if (!pend_data[3]) cursor_addr <= step_addr(cursor_addr, pend_data[2]);
`ifdef TEXTLCD_RX_SHIFT_EN
                else shift_q <= step_shift(shift_q, pend_data[2]);
`endif
              end
              8'b00001???: disp_on <= pend_data[2];
              8'b000001??: begin
                entry_inc <= pend_data[1];
`ifdef TEXTLCD_RX_SHIFT_EN
                entry_s   <= pend_data[0];
`endif
              end
              8'b0000001?: begin
                cursor_addr <= '0;
`ifdef TEXTLCD_RX_SHIFT_EN
                shift_q     <= '0;
`endif
              end
              8'b00000001: begin
                cursor_addr <= '0;
                entry_inc   <= 1'b1;
                sweep_idx   <= '0;
`ifdef TEXTLCD_RX_SHIFT_EN
                shift_q     <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
